// File: rtl/network_sci_sequencer.sv
// network_sci_sequencer: loads NETWORK neuron coefficients over the SCI bus, optionally verifies them,
// and launches single inferences with a bounded wait for the result.
module network_sci_sequencer #(
    parameter int HL_NEURONS  = 8,
    parameter int OL_NEURONS  = 5,
    parameter int FP_WIDTH    = 8,
    parameter int HL_REGS     = 17,
    parameter int OL_REGS     = 9,
    parameter int HL_ADDR_W   = 5,
    parameter int OL_ADDR_W   = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int INF_TIMEOUT = 1000
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             cfg_start,
    input  logic                             verify_en,
    output logic [7:0]                       tbl_addr,
    input  logic [FP_WIDTH-1:0]              tbl_rdata,
    output logic [HL_NEURONS+OL_NEURONS-1:0] sci_csn,
    output logic                             sci_req,
    input  logic                             sci_resp,
    input  logic                             sci_ack,
    input  logic                             infer_start,
    output logic                             net_valid_in,
    input  logic                             net_valid_out,
    input  logic                             net_overflow,
    output logic                             busy,
    output logic                             cfg_ok,
    output logic                             done,
    output logic [1:0]                       err_code,
    output logic                             infer_ovf
);
    localparam int NP = HL_NEURONS + OL_NEURONS;
    localparam int NW = $clog2(NP);
    localparam int FW = 1 + HL_ADDR_W + FP_WIDTH;
    localparam int CW = $clog2(FW + 1);
    localparam int TW = $clog2((INF_TIMEOUT > ACK_TIMEOUT ? INF_TIMEOUT : ACK_TIMEOUT) + 1);

    typedef enum logic [3:0] {IDLE, FETCH, LOAD, SHIFT, RECV, ACKW, CMP, GAP, RDBK, FIN, ISSUE, IWAIT} state_t;

    state_t                state;
    logic [NW-1:0]         neu;
    logic [HL_ADDR_W-1:0]  ridx;
    logic                  rdbk, verify;
    logic [FP_WIDTH-1:0]   wdata, rdata;
    logic [FW-1:0]         sh, frame;
    logic [CW-1:0]         cnt, flen;
    logic [TW-1:0]         tmr;
    logic                  is_hl, last_reg, last_neu;

    // Frames are left-aligned so the shorter OL address still leaves the command bit at the MSB.
    always_comb begin
        is_hl    = neu < NW'(HL_NEURONS);
        last_reg = ridx == (is_hl ? HL_ADDR_W'(HL_REGS - 1) : HL_ADDR_W'(OL_REGS - 1));
        last_neu = neu == NW'(NP - 1);
        frame    = is_hl ? {~rdbk, ridx, tbl_rdata}
                         : FW'({~rdbk, ridx[OL_ADDR_W-1:0], tbl_rdata}) << (HL_ADDR_W - OL_ADDR_W);
        flen     = CW'(1 + (is_hl ? HL_ADDR_W : OL_ADDR_W) + (rdbk ? 0 : FP_WIDTH));
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state        <= IDLE;
            neu          <= '0;
            ridx         <= '0;
            rdbk         <= 1'b0;
            verify       <= 1'b0;
            wdata        <= '0;
            rdata        <= '0;
            sh           <= '0;
            cnt          <= '0;
            tmr          <= '0;
            tbl_addr     <= '0;
            sci_csn      <= '1;
            sci_req      <= 1'b0;
            net_valid_in <= 1'b0;
            busy         <= 1'b0;
            cfg_ok       <= 1'b0;
            done         <= 1'b0;
            err_code     <= 2'b00;
            infer_ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        verify    <= verify_en;
                        rdbk      <= 1'b0;
                        neu       <= '0;
                        ridx      <= '0;
                        tbl_addr  <= '0;
                        cfg_ok    <= 1'b0;
                        err_code  <= 2'b00;
                        infer_ovf <= 1'b0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end else if (infer_start && cfg_ok) begin
                        err_code     <= 2'b00;
                        infer_ovf    <= 1'b0;
                        net_valid_in <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    wdata   <= tbl_rdata;
                    sci_csn <= ~(NP'(1) << neu);
                    sci_req <= frame[FW-1];
                    sh      <= frame << 1;
                    cnt     <= flen;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == CW'(1)) begin
                        sci_req <= 1'b0;
                        cnt     <= CW'(FP_WIDTH);
                        tmr     <= '0;
                        state   <= rdbk ? RECV : ACKW;
                    end else begin
                        sci_req <= sh[FW-1];
                        sh      <= sh << 1;
                        cnt     <= cnt - CW'(1);
                    end
                end
                RECV: begin
                    rdata <= {rdata[FP_WIDTH-2:0], sci_resp};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= ACKW;
                end
                ACKW: begin
                    if (sci_ack) begin
                        if (rdbk) begin
                            state <= CMP;
                        end else begin
                            sci_csn <= '1;
                            state   <= GAP;
                        end
                    end else if (tmr == TW'(ACK_TIMEOUT - 1)) begin
                        err_code <= 2'b10;
                        sci_csn  <= '1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                CMP: begin
                    sci_csn <= '1;
                    if (rdata != wdata) begin
                        err_code <= 2'b01;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (!last_reg) begin
                        ridx     <= ridx + HL_ADDR_W'(1);
                        tbl_addr <= tbl_addr + 8'd1;
                        state    <= FETCH;
                    end else if (!last_neu) begin
                        neu      <= neu + NW'(1);
                        ridx     <= '0;
                        tbl_addr <= tbl_addr + 8'd1;
                        state    <= FETCH;
                    end else begin
                        state <= (verify && !rdbk) ? RDBK : FIN;
                    end
                end
                RDBK: begin
                    rdbk     <= 1'b1;
                    neu      <= '0;
                    ridx     <= '0;
                    tbl_addr <= '0;
                    state    <= FETCH;
                end
                FIN: begin
                    cfg_ok   <= 1'b1;
                    err_code <= 2'b00;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                ISSUE: begin
                    net_valid_in <= 1'b0;
                    tmr          <= '0;
                    state        <= IWAIT;
                end
                IWAIT: begin
                    if (net_valid_out) begin
                        infer_ovf <= net_overflow;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (tmr == TW'(INF_TIMEOUT - 1)) begin
                        err_code <= 2'b11;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_network_sci_sequencer.sv
// tb_network_sci_sequencer: scoreboarded bench with an echoing SCI peripheral model and a scripted NETWORK.
module tb_network_sci_sequencer;
    localparam int NP      = 13;
    localparam int HL      = 8;
    localparam int FP      = 8;
    localparam int ACK_DLY = 2;

    logic          clk, rstn, cfg_start, verify_en, sci_req, sci_resp, sci_ack;
    logic          infer_start, net_valid_in, net_valid_out, net_overflow;
    logic          busy, cfg_ok, done, infer_ovf;
    logic [7:0]    tbl_addr, tbl_rdata;
    logic [NP-1:0] sci_csn;
    logic [1:0]    err_code;

    network_sci_sequencer dut (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .verify_en(verify_en),
        .tbl_addr(tbl_addr), .tbl_rdata(tbl_rdata), .sci_csn(sci_csn), .sci_req(sci_req),
        .sci_resp(sci_resp), .sci_ack(sci_ack), .infer_start(infer_start),
        .net_valid_in(net_valid_in), .net_valid_out(net_valid_out), .net_overflow(net_overflow),
        .busy(busy), .cfg_ok(cfg_ok), .done(done), .err_code(err_code), .infer_ovf(infer_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int n_done = 0, n_frames = 0, vin_count = 0, cyc = 0, last_post = 0;
    int noack_p = -1, bad_p = -1, bad_r = -1;
    logic [18:0] exp_frames[$];
    logic [3:0]  exp_done[$];
    logic [7:0]  tbl [256];
    logic [7:0]  mem [NP][32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic frame_check(input logic [18:0] act);
        logic [18:0] e;
        total++;
        if (exp_frames.size() == 0) begin
            bad++;
            $display("FAIL frame unexpected: got %h want none", act);
        end else begin
            e = exp_frames.pop_front();
            if (act !== e) begin
                bad++;
                $display("FAIL frame %0d: got %h want %h", n_frames, act, e);
            end
        end
    endtask

    // Expected frame record: {write, peripheral, reg, data (0 for reads), single select}.
    task automatic push_cfg(input bit verify, input int nwrites, input int nreads);
        for (int pass = 0; pass < (verify ? 2 : 1); pass++) begin
            int k;
            k = 0;
            for (int p = 0; p < NP; p++)
                for (int r = 0; r < (p < HL ? 17 : 9); r++) begin
                    if (pass == 0 ? k < nwrites : k < nreads)
                        exp_frames.push_back({pass == 0, 4'(p), 5'(r), pass == 0 ? 8'(k) : 8'h00, 1'b1});
                    k++;
                end
        end
    endtask

    task automatic pulse(input bit c, input bit i, input bit v);
        @(negedge clk);
        cfg_start = c;
        infer_start = i;
        verify_en = v;
        @(negedge clk);
        cfg_start = 1'b0;
        infer_start = 1'b0;
        #1;
    endtask

    task automatic wait_done(input int n0, input int budget, input string name);
        int k;
        k = 0;
        while (n_done == n0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, 32'(n_done != n0), 1);
    endtask

    always @(negedge clk) tbl_rdata = tbl[tbl_addr];
    always @(negedge clk) cyc++;
    always @(negedge clk) if (net_valid_in) vin_count++;

    always @(negedge clk) begin
        if (!rstn && done) begin
            n_done++;
            total++;
            if (exp_done.size() == 0) begin
                bad++;
                $display("FAIL done unexpected: got %b want none", {err_code, cfg_ok, infer_ovf});
            end else begin
                logic [3:0] e;
                e = exp_done.pop_front();
                if ({err_code, cfg_ok, infer_ovf} !== e) begin
                    bad++;
                    $display("FAIL done result: got %b want %b", {err_code, cfg_ok, infer_ovf}, e);
                end
            end
        end
    end

    // SCI peripheral: decodes frames, stores writes, returns stored words on reads, acks after ACK_DLY.
    int fi = 0, post = 0, aw = 5, fp = 0;
    logic fw, fone;
    logic [4:0] fa;
    logic [7:0] fd, rd_word;
    always @(negedge clk) begin
        sci_ack = 1'b0;
        if (rstn || &sci_csn) begin
            if (fi > 0) last_post = post;
            fi = 0;
            post = 0;
        end else begin
            if (fi == 0) begin
                for (int p = 0; p < NP; p++) if (!sci_csn[p]) fp = p;
                fone = $countones(~sci_csn) == 1;
                fw = sci_req;
                fa = '0;
                fd = '0;
            end
            aw = fp < HL ? 5 : 4;
            if (fi >= 1 && fi <= aw) fa = {fa[3:0], sci_req};
            else if (fi > aw && fi <= aw + FP) begin
                if (fw) fd = {fd[6:0], sci_req};
                else sci_resp = rd_word[FP - 1 - (fi - aw - 1)];
            end else if (fi > aw + FP) post++;
            if (fi == aw) rd_word = (fp == bad_p && fa == 5'(bad_r)) ? 8'hA5 : mem[fp][fa];
            if (fi == aw + FP) begin
                if (fw) mem[fp][fa] = fd;
                n_frames++;
                frame_check({fw, 4'(fp), fa, fd, fone});
            end
            if (post == ACK_DLY && fp != noack_p) sci_ack = 1'b1;
            fi++;
        end
    end

    initial begin
        int n0, f0, v0, t0, k;
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        for (int p = 0; p < NP; p++) for (int r = 0; r < 32; r++) mem[p][r] = 8'h00;
        rstn = 1'b0;
        cfg_start = 1'b0;
        verify_en = 1'b0;
        infer_start = 1'b0;
        net_valid_out = 1'b0;
        net_overflow = 1'b0;
        sci_resp = 1'b0;
        #2 rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset csn", sci_csn, 13'h1fff);
        check("reset busy/done/ok", {busy, done, cfg_ok}, 0);
        check("reset err/ovf", {err_code, infer_ovf}, 0);
        check("reset req/vin/addr", {sci_req, net_valid_in, tbl_addr}, 0);
        @(negedge clk) rstn = 1'b0;

        pulse(0, 1, 0);
        check("infer ignored before cfg", {busy, net_valid_in}, 0);

        // Full configuration with readback; restart attempts while busy must be ignored.
        n0 = n_done;
        f0 = n_frames;
        push_cfg(1, 181, 181);
        exp_done.push_back(4'b0010);
        pulse(1, 0, 1);
        check("busy after cfg_start", busy, 1);
        repeat (200) @(negedge clk);
        pulse(1, 1, 0);
        wait_done(n0, 10000, "cfg verify done");
        repeat (20) @(negedge clk);
        #1;
        check("cfg verify frames", n_frames - f0, 362);
        check("cfg verify single done", n_done - n0, 1);
        check("cfg verify queue empty", exp_frames.size(), 0);

        // Inference with overflow.
        n0 = n_done;
        v0 = vin_count;
        exp_done.push_back(4'b0011);
        pulse(0, 1, 0);
        check("vin in issue", net_valid_in, 1);
        @(negedge clk);
        #1;
        check("vin one cycle", net_valid_in, 0);
        repeat (35) @(negedge clk);
        net_valid_out = 1'b1;
        net_overflow = 1'b1;
        @(negedge clk);
        net_valid_out = 1'b0;
        net_overflow = 1'b0;
        wait_done(n0, 50, "infer done");
        check("infer vin cycles", vin_count - v0, 1);
        check("infer ovf", {infer_ovf, err_code}, 3'b100);

        // Inference timeout, then simultaneous starts.
        n0 = n_done;
        exp_done.push_back(4'b1110);
        pulse(0, 1, 0);
        t0 = cyc;
        wait_done(n0, 1100, "infer timeout done");
        check("infer timeout cycles", cyc - t0, 1001);
        check("infer timeout busy", busy, 0);
        repeat (5) @(negedge clk);
        #1;
        check("err holds", err_code, 2'b11);
        n0 = n_done;
        v0 = vin_count;
        push_cfg(0, 181, 0);
        exp_done.push_back(4'b0010);
        pulse(1, 1, 0);
        wait_done(n0, 5000, "arb cfg done");
        check("arb no vin", vin_count - v0, 0);
        check("arb queue empty", exp_frames.size(), 0);

        // Readback mismatch on peripheral 3 bias.
        bad_p = 3;
        bad_r = 16;
        n0 = n_done;
        f0 = n_frames;
        push_cfg(1, 181, 68);
        exp_done.push_back(4'b0100);
        pulse(1, 0, 1);
        wait_done(n0, 10000, "mismatch done");
        repeat (100) @(negedge clk);
        #1;
        check("mismatch frames", n_frames - f0, 249);
        check("mismatch csn idle", sci_csn, 13'h1fff);
        bad_p = -1;
        pulse(0, 1, 0);
        check("infer ignored no cfg_ok", {busy, net_valid_in}, 0);
        check("err 01 holds", err_code, 2'b01);

        // Peripheral 9 never acks.
        noack_p = 9;
        n0 = n_done;
        push_cfg(0, 146, 0);
        exp_done.push_back(4'b1000);
        pulse(1, 0, 0);
        wait_done(n0, 5000, "ack timeout done");
        check("ack timeout cycles", last_post, 64);
        check("ack timeout csn", sci_csn, 13'h1fff);
        check("ack timeout queue empty", exp_frames.size(), 0);
        noack_p = -1;

        // Reset in the middle of a write frame, then a clean restart.
        f0 = n_frames;
        push_cfg(0, 3, 0);
        pulse(1, 0, 0);
        k = 0;
        while (n_frames < f0 + 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        while (&sci_csn && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        check("mid-frame select low", 32'(&sci_csn), 0);
        rstn = 1'b1;
        #1;
        check("async reset csn", sci_csn, 13'h1fff);
        check("async reset busy", busy, 0);
        @(negedge clk);
        rstn = 1'b0;
        exp_frames.delete();
        n0 = n_done;
        push_cfg(0, 181, 0);
        exp_done.push_back(4'b0010);
        pulse(1, 0, 0);
        check("restart table index", tbl_addr, 0);
        wait_done(n0, 5000, "restart done");
        check("restart queue empty", exp_frames.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
